iiitb_sd_prog: RTL and testbench

- Parametrised, runtime-programmable serial sequence detector. Moore-style, with a registered output.
- Successor to the fixed 4-bit Moore detector. Adds the following:
  - pattern length and value loadable up to MAX_LEN bits;
  - selectable overlapping or non-overlapping detection;
  - an input-valid qualifier;
  - a saturating match counter and a config error flag.
- Sits on the serial bit-stream path, fed one bit per accepted cycle.

---
 rtl/iiitb_sd_prog.sv | 116 +++++++++++
 tb/tb_iiitb_sd_prog.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_sd_prog.sv
// Runtime-programmable serial sequence detector with a registered Moore output,
// selectable overlap, a saturating match counter and a sticky config-error flag.
module iiitb_sd_prog #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_vld,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_cnt,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [MAX_LEN-1:0] DefPat = MAX_LEN'(4'b1010);
  localparam logic [LEN_W-1:0]   DefLen = LEN_W'(4);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               accept;
  logic               cfg_legal;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;
  logic               match;

  always_comb begin
    accept    = din_vld & ~cfg_we;
    cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    hist_n    = {hist_q[MAX_LEN-2:0], din};
    fill_n    = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
    // Only the low len bits of history and pattern take part in the compare.
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    match = accept && (fill_n == len_q) && (((hist_n ^ pat_q) & mask) == '0);
  end

  always_comb begin
    pat_d     = pat_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    if (cfg_we) begin
      if (cfg_legal) begin
        pat_d     = cfg_pat;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        hist_d    = '0;
        fill_d    = '0;
        y_d       = 1'b0;
        err_d     = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (accept) begin
      hist_d = hist_n;
      y_d    = match;
      // Non-overlapping mode discards history so the next hit needs len fresh bits.
      fill_d = (match && !overlap_q) ? '0 : fill_n;
    end

    if (match && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (clr_cnt) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q     <= DefPat;
      len_q     <= DefLen;
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      y_q       <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign y         = y_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_iiitb_sd_prog.sv
// Scoreboard bench for iiitb_sd_prog: a bit-queue reference model predicts y, match_cnt
// and cfg_err each cycle; a separate monitor compares them against the DUT.
module tb_iiitb_sd_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               din = 1'b0;
  logic               din_vld = 1'b0;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pat = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               clr_cnt = 1'b0;
  logic               y;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  iiitb_sd_prog #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_vld    (din_vld),
    .cfg_we     (cfg_we),
    .cfg_pat    (cfg_pat),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .clr_cnt    (clr_cnt),
    .y          (y),
    .match_cnt  (match_cnt),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit y;
    int cnt;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: the bits seen since the last discard, plus active config.
  bit [MAX_LEN-1:0] m_pat;
  int               m_len;
  bit               m_ov;
  bit               win[$];
  bit               m_y;
  int               m_cnt;
  bit               m_err;

  task automatic model_reset();
    m_pat      = '0;
    m_pat[3:0] = 4'b1010;
    m_len      = 4;
    m_ov       = 1'b1;
    win.delete();
    m_y        = 1'b0;
    m_cnt      = 0;
    m_err      = 1'b0;
  endtask

  // Last m_len received bits, oldest first, must equal pat[len-1] .. pat[0].
  function automatic bit model_match();
    if (win.size() < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      if (win[win.size() - m_len + j] != m_pat[m_len-1-j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic push_exp(input int c);
    exp_t e;
    e.cyc = c;
    e.y   = m_y;
    e.cnt = m_cnt;
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit d, input bit v, input bit we, input logic [MAX_LEN-1:0] p,
                      input int l, input bit ov, input bit clr);
    bit mt;
    @(posedge clk);
    #1;
    din         = d;
    din_vld     = v;
    cfg_we      = we;
    cfg_pat     = p;
    cfg_len     = LEN_W'(l);
    cfg_overlap = ov;
    clr_cnt     = clr;
    if (we) begin
      if (l >= 1 && l <= MAX_LEN) begin
        m_pat = p;
        m_len = l;
        m_ov  = ov;
        win.delete();
        m_y   = 1'b0;
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (v) begin
      win.push_back(d);
      if (win.size() > MAX_LEN) void'(win.pop_front());
      mt  = model_match();
      m_y = mt;
      if (mt) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_ov) win.delete();
      end
    end
    if (clr) m_cnt = 0;
    push_exp(cyc + 1);
  endtask

  task automatic bit_in(input bit d);
    step(d, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] p, input int l, input bit ov);
    step(1'b0, 1'b0, 1'b1, p, l, ov, 1'b0);
  endtask

  task automatic clr_only();
    step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
  endtask

  task automatic bits_in(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
  endtask

  // Reset asserted between edges; the check lands on this cycle's negedge.
  task automatic async_rst();
    @(posedge clk);
    #2;
    reset   = 1'b0;
    din_vld = 1'b0;
    cfg_we  = 1'b0;
    clr_cnt = 1'b0;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= cyc) void'(exp_q.pop_back());
    model_reset();
    push_exp(cyc);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("y", (y === 1'b1) ? 1 : ((y === 1'b0) ? 0 : -1), int'(e.y));
        check("match_cnt", $isunknown(match_cnt) ? -1 : int'(match_cnt), e.cnt);
        check("cfg_err", (cfg_err === 1'b1) ? 1 : ((cfg_err === 1'b0) ? 0 : -1), int'(e.err));
      end
    end
  end

  initial begin : stim
    int l;
    int n;
    model_reset();
    @(posedge clk);
    #1;
    push_exp(cyc);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Default 1010, overlapping.
    bits_in(16'b101010, 6);
    idle();

    // Illegal lengths keep the default pattern alive; a legal write clears the flag.
    cfg(8'hFF, 0, 1'b0);
    cfg(8'hFF, 9, 1'b0);
    bits_in(16'b1010, 4);
    idle();
    cfg(8'b1011_0110, 8, 1'b0);
    idle();

    // Eight-bit non-overlapping pattern with an idle gap between bits 4 and 5.
    clr_only();
    bits_in(16'b1011, 4);
    idle();
    idle();
    idle();
    bits_in(16'b0110, 4);
    idle();
    bits_in(16'b1011_0110, 8);
    idle();
    idle();

    // 111: overlapping then non-overlapping.
    clr_only();
    cfg(8'b111, 3, 1'b1);
    bits_in(16'b11111, 5);
    cfg(8'b111, 3, 1'b0);
    bits_in(16'b11111, 5);

    // len=1 saturation, then clear colliding with a match.
    cfg(8'b1, 1, 1'b1);
    clr_only();
    for (int i = 0; i < CNT_MAX + 5; i++) bit_in(1'b1);
    step(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
    bit_in(1'b0);

    // A bit presented with a config write is dropped.
    cfg(8'b1010, 4, 1'b1);
    bits_in(16'b101, 3);
    step(1'b0, 1'b1, 1'b1, 8'b1010, 4, 1'b1, 1'b0);
    bits_in(16'b1010, 4);

    // Mid-pattern asynchronous reset after 101.
    async_rst();
    bits_in(16'b101, 3);
    async_rst();
    bits_in(16'b01010, 5);
    idle();

    // Randomised configurations and streams.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) l = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(9, 15);
      else l = $urandom_range(1, 8);
      cfg(MAX_LEN'($urandom), l, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int j = m_len - 1; j >= 0; j--) begin
            if ($urandom_range(0, 4) == 0) idle();
            step(m_pat[j], 1'b1, 1'b0, '0, 0, 1'b0, 1'($urandom_range(0, 39) == 0));
          end
        end else begin
          n = $urandom_range(1, 6);
          for (int j = 0; j < n; j++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0), 1'b0, '0, 0, 1'b0,
                 1'($urandom_range(0, 39) == 0));
          end
        end
      end
      if (s == 20) async_rst();
    end
    idle();

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
